// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories. The controller takes the master side.
interface multicycle_ctrl_if;
    logic imem_req;    // instruction fetch request
    logic imem_ready;  // fetch data valid this cycle
    logic dmem_req;    // data access request
    logic dmem_we;     // 1 = store, 0 = load; qualified by dmem_req
    logic dmem_ready;  // data access complete this cycle

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// One instruction in flight; decoder fields are captured in DECODE so EXEC/MEM/WB
// outputs depend only on state plus the latched instruction class.
// Optional build macro PERF_COUNTERS_EN adds cycle_cnt/instret_cnt outputs.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 func7_b5,
    input  logic                 rd_zero,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [3:0]           alu_op,
    output logic                 alu_src_b,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 illegal,
    output logic [2:0]           state_o
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
`endif
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpcR    = 7'b0110011;
    localparam logic [6:0] OpcI    = 7'b0010011;
    localparam logic [6:0] OpcLd   = 7'b0000011;
    localparam logic [6:0] OpcSt   = 7'b0100011;
    localparam logic [6:0] OpcBr   = 7'b1100011;
    localparam logic [6:0] OpcJal  = 7'b1101111;
    localparam logic [6:0] OpcJalr = 7'b1100111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;

    // Timeout disabled when MEM_TIMEOUT == 0; TmoLast is the final waiting cycle index.
    localparam bit          TmoEn   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TmoLast = TmoEn ? (MEM_TIMEOUT - 32'd1) : 32'd0;

    // A zero-width counter is meaningless; nothing is elaborated for it.
    if (CNT_W == 0) begin : g_cnt_w_zero
    end

    state_e      state_q, state_d;
    logic [31:0] tmo_q, tmo_d;
    logic [6:0]  opc_q;
    logic [2:0]  f3_q;
    logic        f7_q;
    logic        rdz_q;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;
    logic [3:0] alu_dec;

    logic imem_req_c, dmem_req_c, dmem_we_c;
    logic ir_we_c, pc_we_c, alu_src_b_c, reg_we_c, illegal_c;
    logic [1:0] pc_sel_c, wb_sel_c;
    logic [3:0] alu_op_c;

    // Instruction class of the latched opcode.
    always_comb begin
        is_r    = (opc_q == OpcR);
        is_i    = (opc_q == OpcI);
        is_ld   = (opc_q == OpcLd);
        is_st   = (opc_q == OpcSt);
        is_br   = (opc_q == OpcBr);
        is_jal  = (opc_q == OpcJal);
        is_jalr = (opc_q == OpcJalr);
    end

    // ALU operation: func3/func7 only matter for R/I; ADDI never becomes SUB.
    always_comb begin
        alu_dec = AluAdd;
        if (is_br) begin
            alu_dec = AluSub;
        end else if (is_r || is_i) begin
            case (f3_q)
                3'd0:    alu_dec = (is_r && f7_q) ? AluSub : AluAdd;
                3'd1:    alu_dec = AluSll;
                3'd2:    alu_dec = AluSlt;
                3'd3:    alu_dec = AluSltu;
                3'd4:    alu_dec = AluXor;
                3'd5:    alu_dec = f7_q ? AluSra : AluSrl;
                3'd6:    alu_dec = AluOr;
                default: alu_dec = AluAnd;
            endcase
        end
    end

    // Next-state, timeout counter and control decode.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 2'd0;
        alu_op_c    = AluAdd;
        alu_src_b_c = 1'b0;
        reg_we_c    = 1'b0;
        wb_sel_c    = 2'd0;
        illegal_c   = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_we_c = 1'b1;
                    tmo_d   = '0;
                    state_d = StDecode;
                end else if (TmoEn) begin
                    // Ready arriving in the limit cycle takes the branch above.
                    if (tmo_q == TmoLast) begin
                        tmo_d   = '0;
                        state_d = StTrap;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            StDecode: begin
                if (opcode inside {OpcR, OpcI, OpcLd, OpcSt, OpcBr, OpcJal, OpcJalr}) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                end
            end
            StExec: begin
                alu_op_c    = alu_dec;
                alu_src_b_c = is_i || is_ld || is_st || is_jalr;
                if (is_br) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = br_taken ? 2'd1 : 2'd0;
                    state_d  = StFetch;
                end else if (is_ld || is_st) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_st;
                if (mem.dmem_ready) begin
                    tmo_d = '0;
                    if (is_st) begin
                        pc_we_c = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (TmoEn) begin
                    if (tmo_q == TmoLast) begin
                        tmo_d   = '0;
                        state_d = StTrap;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end
            StWb: begin
                reg_we_c = !rdz_q;
                wb_sel_c = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                pc_we_c  = 1'b1;
                pc_sel_c = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                state_d  = StFetch;
            end
            StTrap: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // State, timeout counter and decoder-field capture (fields valid from DECODE on).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            tmo_q   <= '0;
            opc_q   <= '0;
            f3_q    <= '0;
            f7_q    <= 1'b0;
            rdz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (state_q == StDecode) begin
                opc_q <= opcode;
                f3_q  <= func3;
                f7_q  <= func7_b5;
                rdz_q <= rd_zero;
            end
        end
    end

    // Outputs forced low while reset is asserted so an in-flight request drops at once.
    always_comb begin
        mem.imem_req = imem_req_c  & rst_n;
        mem.dmem_req = dmem_req_c  & rst_n;
        mem.dmem_we  = dmem_we_c   & rst_n;
        ir_we        = ir_we_c     & rst_n;
        pc_we        = pc_we_c     & rst_n;
        pc_sel       = rst_n ? pc_sel_c : 2'd0;
        alu_op       = rst_n ? alu_op_c : 4'd0;
        alu_src_b    = alu_src_b_c & rst_n;
        reg_we       = reg_we_c    & rst_n;
        wb_sel       = rst_n ? wb_sel_c : 2'd0;
        illegal      = illegal_c   & rst_n;
        state_o      = state_q;
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             retire;

    // An instruction retires whenever control returns to FETCH after EXEC/MEM/WB.
    always_comb begin
        retire = (state_d == StFetch) &&
                 ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));
    end

    // Free-running counters, frozen once trapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else if (state_q != StTrap) begin
            cycle_q <= cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (retire) begin
                instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule
